muxer_scan: RTL and testbench

MUXER_SCAN -- requirements
Module: muxer_scan

---
 rtl/muxer_pkg.sv | 17 +
 rtl/muxer_n.sv | 29 ++
 rtl/muxer_scan.sv | 191 +++++++++++++++++++
 tb/tb_muxer_scan.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/muxer_pkg.sv
// Shared types for the scanning channel multiplexer.
//   state_e : controller state (IDLE, MANUAL, SCAN)
//   mode_e  : encoding of the 'mode' input pin
package muxer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MANUAL = 2'd1,
        SCAN   = 2'd2
    } state_e;

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_e;

endpackage

// File: rtl/muxer_n.sv
// Combinational N_CH-to-1 channel selector.
//   in  : N_CH packed channels, channel k at bits [k*W +: W]
//   idx : channel index; out-of-range indices return zero
//   out : selected channel
module muxer_n #(
    parameter int  N_CH = 16,
    parameter int  W    = 1,
    localparam int SW   = $clog2(N_CH)
) (
    input  logic [N_CH*W-1:0] in,
    input  logic [SW-1:0]     idx,
    output logic [W-1:0]      out
);

    localparam logic [SW:0] N_LIM = N_CH[SW:0];

    logic [W-1:0] ch [N_CH];

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            assign ch[gi] = in[gi*W +: W];
        end
    endgenerate

    // Guard matters only when N_CH is not a power of two.
    assign out = ({1'b0, idx} < N_LIM) ? ch[idx] : '0;

endmodule

// File: rtl/muxer_scan.sv
// Registered channel sampler with manual and automatic scan modes.
//   clk, rst_n : clock, synchronous active-low reset
//   in         : N_CH packed W-bit channels
//   en         : run enable; low returns the controller to IDLE
//   mode       : 0 = channel from sel, 1 = scan over ch_mask
//   sel        : manual channel index
//   ch_mask    : channels visited in scan mode
//   q, q_ch    : captured sample and its channel index
//   q_valid    : sample pending; accepted when q_valid & q_ready
//   q_ready    : consumer accept
module muxer_scan
    import muxer_pkg::*;
#(
    parameter int  N_CH  = 16,
    parameter int  W     = 1,
    parameter int  DWELL = 4,
    localparam int SW    = $clog2(N_CH),
    localparam int DW    = $clog2(DWELL + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CH*W-1:0] in,
    input  logic              en,
    input  logic              mode,
    input  logic [SW-1:0]     sel,
    input  logic [N_CH-1:0]   ch_mask,
    output logic [W-1:0]      q,
    output logic [SW-1:0]     q_ch,
    output logic              q_valid,
    input  logic              q_ready
);

    localparam int          LAST_I  = N_CH - 1;
    localparam logic [SW:0] N_LIM   = N_CH[SW:0];
    localparam logic [SW-1:0] LAST  = LAST_I[SW-1:0];
    localparam logic [DW-1:0] DWELL_W = DWELL[DW-1:0];

    state_e        state_reg, state_next;
    logic [SW-1:0] ptr_reg, ptr_next;
    logic [DW-1:0] dwell_reg, dwell_next;
    logic [W-1:0]  q_reg, q_next;
    logic [SW-1:0] q_ch_reg, q_ch_next;
    logic          q_valid_reg, q_valid_next;

    logic [SW-1:0] cur_ptr;
    logic          ptr_ok;
    logic          capture;
    logic          sel_ok;
    logic          any_mask;
    logic [SW-1:0] scan_tgt;
    logic [SW-1:0] scan_adv;
    logic [DW-1:0] dwell_base;
    logic [DW-1:0] dwell_inc;
    logic [W-1:0]  mux_out;

    // First index at or after 'start' whose mask bit is set, wrapping at
    // N_CH. Iterating from the far end lets the nearest hit win.
    function automatic logic [SW-1:0] first_set(input logic [N_CH-1:0] m,
                                                 input logic [SW-1:0]   start);
        logic [SW-1:0] r;
        logic [SW-1:0] idx;
        int            j;
        r = start;
        for (int i = N_CH - 1; i >= 0; i--) begin
            j = int'(start) + i;
            if (j >= N_CH) begin
                j = j - N_CH;
            end
            idx = j[SW-1:0];
            if (m[idx]) begin
                r = idx;
            end
        end
        return r;
    endfunction

    function automatic logic [SW-1:0] wrap_inc(input logic [SW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign sel_ok   = ({1'b0, sel} < N_LIM);
    assign any_mask = |ch_mask;
    // If the mask moved under the pointer, the target is the next masked
    // channel; otherwise it is the pointer itself.
    assign scan_tgt = first_set(ch_mask, ptr_reg);
    assign scan_adv = first_set(ch_mask, wrap_inc(scan_tgt));

    // Dwell restarts when the pointer is forced off an unmasked channel.
    assign dwell_base = ch_mask[ptr_reg] ? dwell_reg : '0;
    assign dwell_inc  = dwell_base + 1'b1;

    always_comb begin
        cur_ptr = sel;
        ptr_ok  = 1'b0;
        case (state_reg)
            MANUAL: begin
                cur_ptr = sel;
                ptr_ok  = sel_ok;
            end
            SCAN: begin
                cur_ptr = scan_tgt;
                ptr_ok  = any_mask;
            end
            default: begin
                cur_ptr = sel;
                ptr_ok  = 1'b0;
            end
        endcase
        capture = ptr_ok & (~q_valid_reg | q_ready);
    end

    muxer_n #(
        .N_CH (N_CH),
        .W    (W)
    ) u_mux (
        .in  (in),
        .idx (cur_ptr),
        .out (mux_out)
    );

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        if (!en) begin
            state_next = IDLE;
        end else if (mode == MODE_SCAN) begin
            state_next = SCAN;
        end else begin
            state_next = MANUAL;
        end
    end

    // Output register next values
    always_comb begin
        q_next       = q_reg;
        q_ch_next    = q_ch_reg;
        q_valid_next = q_valid_reg;
        if (capture) begin
            q_next       = mux_out;
            q_ch_next    = cur_ptr;
            q_valid_next = 1'b1;
        end else if (q_valid_reg && q_ready) begin
            q_valid_next = 1'b0;
        end
    end

    // Scan pointer and dwell counter next values
    always_comb begin
        ptr_next   = ptr_reg;
        dwell_next = dwell_reg;
        if (state_reg == SCAN && any_mask) begin
            ptr_next   = scan_tgt;
            dwell_next = dwell_base;
            if (capture) begin
                if (dwell_inc == DWELL_W) begin
                    dwell_next = '0;
                    ptr_next   = scan_adv;
                end else begin
                    dwell_next = dwell_inc;
                end
            end
        end
        // Entering scan restarts the dwell but keeps the pointer.
        if (state_next == SCAN && state_reg != SCAN) begin
            dwell_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            ptr_reg     <= '0;
            dwell_reg   <= '0;
            q_reg       <= '0;
            q_ch_reg    <= '0;
            q_valid_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ptr_reg     <= ptr_next;
            dwell_reg   <= dwell_next;
            q_reg       <= q_next;
            q_ch_reg    <= q_ch_next;
            q_valid_reg <= q_valid_next;
        end
    end

    assign q       = q_reg;
    assign q_ch    = q_ch_reg;
    assign q_valid = q_valid_reg;

endmodule

// File: tb/tb_muxer_scan.sv
// Self-checking bench for muxer_scan: directed scenarios plus randomized
// stimulus compared each cycle against a behavioural model.
module tb_muxer_scan;

    localparam int NC = 16;
    localparam int DW = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] in_v;
    logic         en;
    logic         mode;
    logic [3:0]   sel;
    logic [15:0]  ch_mask;
    logic [7:0]   q;
    logic [3:0]   q_ch;
    logic         q_valid;
    logic         q_ready;

    logic [39:0]  in5;
    logic [2:0]   sel5;
    logic [4:0]   mask5;
    logic [7:0]   q5;
    logic [2:0]   qch5;
    logic         qv5;

    int checks_total  = 0;
    int checks_passed = 0;

    // model state: 0 idle, 1 manual, 2 scan
    int m_state, m_ptr, m_dwell, m_q, m_qch, m_qv;

    always #5 clk = ~clk;

    muxer_scan #(.N_CH(16), .W(8), .DWELL(2)) dut (
        .clk(clk), .rst_n(rst_n), .in(in_v), .en(en), .mode(mode),
        .sel(sel), .ch_mask(ch_mask), .q(q), .q_ch(q_ch),
        .q_valid(q_valid), .q_ready(q_ready)
    );

    muxer_scan #(.N_CH(5), .W(8), .DWELL(2)) dut5 (
        .clk(clk), .rst_n(rst_n), .in(in5), .en(en), .mode(mode),
        .sel(sel5), .ch_mask(mask5), .q(q5), .q_ch(qch5),
        .q_valid(qv5), .q_ready(q_ready)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        checks_total++;
        if (got == exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int first_masked(input int start);
        for (int k = 0; k < NC; k++) begin
            if (((ch_mask >> ((start + k) % NC)) & 16'd1) != 0) begin
                return (start + k) % NC;
            end
        end
        return start;
    endfunction

    // Advance the model across one rising edge using current inputs.
    task automatic model_step();
        int tgt, d, nst;
        bit ok, fire;
        logic [127:0] tmp;
        if (!rst_n) begin
            m_state = 0; m_ptr = 0; m_dwell = 0;
            m_q = 0; m_qch = 0; m_qv = 0;
            return;
        end
        ok = 0; tgt = 0;
        if (m_state == 1 && int'(sel) < NC) begin
            ok = 1; tgt = int'(sel);
        end
        if (m_state == 2 && ch_mask != 0) begin
            ok = 1; tgt = first_masked(m_ptr);
        end
        fire = ok && (m_qv == 0 || q_ready);
        if (fire) begin
            tmp  = in_v >> (tgt * 8);
            m_q  = int'(tmp[7:0]);
            m_qch = tgt;
            m_qv = 1;
        end else if (m_qv == 1 && q_ready) begin
            m_qv = 0;
        end
        if (m_state == 2 && ch_mask != 0) begin
            d = (tgt == m_ptr) ? m_dwell : 0;
            if (fire) begin
                d++;
                if (d == DW) begin
                    d = 0;
                    tgt = first_masked((tgt + 1) % NC);
                end
            end
            m_ptr = tgt;
            m_dwell = d;
        end
        nst = !en ? 0 : (mode ? 2 : 1);
        if (nst == 2 && m_state != 2) m_dwell = 0;
        m_state = nst;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check("model_q_valid", q_valid, m_qv);
        check("model_q", q, m_q);
        check("model_q_ch", q_ch, m_qch);
    endtask

    task automatic rand_in();
        in_v = {$urandom, $urandom, $urandom, $urandom};
    endtask

    int seq33[8] = '{0, 0, 3, 3, 0, 0, 3, 3};
    logic [7:0] hold_q;
    logic [3:0] hold_ch;
    logic [7:0] exp_q;

    initial begin
        rst_n = 0; en = 0; mode = 0; sel = 0; ch_mask = 0; q_ready = 0;
        in_v = 0; in5 = 0; sel5 = 0; mask5 = 0;
        m_state = 0; m_ptr = 0; m_dwell = 0; m_q = 0; m_qch = 0; m_qv = 0;
        cycle();
        cycle();
        check("reset_qv", q_valid, 0);
        check("reset_q", q, 0);
        rst_n = 1;

        // Manual capture latency
        rand_in();
        in_v[5*8 +: 8] = 8'hA5;
        mode = 0; sel = 5; q_ready = 1; en = 1;
        cycle();
        check("man_edge1_qv", q_valid, 0);
        cycle();
        check("man_q", q, 8'hA5);
        check("man_qch", q_ch, 5);
        check("man_qv", q_valid, 1);

        // Backpressure
        q_ready = 0;
        hold_q = q; hold_ch = q_ch;
        for (int i = 0; i < 5; i++) begin
            rand_in();
            cycle();
            check("bp_q", q, hold_q);
            check("bp_qch", q_ch, hold_ch);
            check("bp_qv", q_valid, 1);
        end
        q_ready = 1;
        rand_in();
        exp_q = in_v[47:40];
        cycle();
        check("bp_resume_q", q, exp_q);

        // en falls with a pending sample
        q_ready = 0;
        cycle();
        hold_q = q;
        en = 0;
        for (int i = 0; i < 3; i++) begin
            rand_in();
            cycle();
            check("enoff_hold_q", q, hold_q);
            check("enoff_hold_qv", q_valid, 1);
        end
        q_ready = 1;
        cycle();
        check("enoff_accept_qv", q_valid, 0);
        for (int i = 0; i < 3; i++) begin
            rand_in();
            cycle();
            check("enoff_idle_qv", q_valid, 0);
        end

        // Scan sequence over mask 0x0009
        rst_n = 0;
        cycle();
        rst_n = 1;
        mode = 1; ch_mask = 16'h0009; q_ready = 1; en = 1;
        cycle();
        for (int i = 0; i < 8; i++) begin
            rand_in();
            cycle();
            check("scan_seq_qch", q_ch, seq33[i]);
            check("scan_seq_qv", q_valid, 1);
        end

        // Mask drops to zero then is restored
        ch_mask = 16'h0004;
        for (int i = 0; i < 4; i++) begin
            rand_in();
            cycle();
            check("mask4_qch", q_ch, 2);
        end
        ch_mask = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("mask0_qv", q_valid, 0);
        end
        ch_mask = 16'h0100;
        for (int i = 0; i < 3; i++) begin
            rand_in();
            cycle();
            check("mask100_qch", q_ch, 8);
            check("mask100_qv", q_valid, 1);
        end

        // Reset mid-scan with a sample pending
        q_ready = 0;
        cycle();
        rst_n = 0;
        cycle();
        check("rst_mid_q", q, 0);
        check("rst_mid_qch", q_ch, 0);
        check("rst_mid_qv", q_valid, 0);
        rst_n = 1;

        // 5-channel build: out-of-range select never captures
        mode = 0; en = 1; q_ready = 1; sel5 = 3'd6;
        in5 = 40'h3C_11_22_33_44;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("n5_sel6_qv", qv5, 0);
        end
        sel5 = 3'd4;
        cycle();
        check("n5_sel4_qv", qv5, 1);
        check("n5_sel4_q", q5, 8'h3C);
        check("n5_sel4_qch", qch5, 4);

        // Randomized run against the model
        for (int i = 0; i < 600; i++) begin
            rst_n = ($urandom_range(63) != 0);
            en = ($urandom_range(15) != 0);
            if ($urandom_range(29) == 0) mode = ~mode;
            if ($urandom_range(19) == 0) begin
                case ($urandom_range(3))
                    0: ch_mask = 16'h0;
                    1: ch_mask = 16'h1 << $urandom_range(15);
                    default: ch_mask = 16'($urandom & $urandom);
                endcase
            end
            sel = 4'($urandom);
            q_ready = ($urandom_range(3) != 0);
            rand_in();
            cycle();
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
